// File: rtl/dm_lsu_pkg.sv
// Shared types for the data-memory load/store unit: opcodes, exception codes,
// FSM states and the store-classification helper.
package dm_lsu_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_ADEL = 2'd1,
    EXC_ADES = 2'd2
  } exc_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic is_store(op_e op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// CPU request/response channel plus byte-enabled data-memory port of the LSU.
// slave = the LSU itself, master = the CPU pipeline and memory around it.
interface dm_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import dm_lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  op_e               req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [31:0]       req_pc;

  logic [ADDR_W-1:0] dm_a;
  logic [DATA_W-1:0] dm_wd;
  logic [3:0]        dm_write;
  logic [31:0]       dm_pc;
  logic [DATA_W-1:0] dm_rd;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  exc_e              rsp_exc;
  logic [ADDR_W-1:0] rsp_badaddr;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, dm_rd, rsp_ready,
    output req_ready, dm_a, dm_wd, dm_write, dm_pc,
           rsp_valid, rsp_rdata, rsp_exc, rsp_badaddr
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, dm_rd, rsp_ready,
    input  req_ready, dm_a, dm_wd, dm_write, dm_pc,
           rsp_valid, rsp_rdata, rsp_exc, rsp_badaddr
  );

endinterface

// File: rtl/dm_lsu_lane.sv
// Byte-lane steering: store enables/replication, load extraction/extension,
// and the alignment check, all purely combinational.
module dm_lsu_lane
  import dm_lsu_pkg::*;
(
  input  op_e         i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rd,
  output logic [3:0]  o_be,
  output logic [31:0] o_wd,
  output logic [31:0] o_ldata,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rd[8*i_lane +: 8];
  assign w_half = i_lane[1] ? i_rd[31:16] : i_rd[15:0];

  always_comb begin
    o_be       = 4'b0000;
    o_wd       = i_wdata;
    o_ldata    = i_rd;
    o_misalign = 1'b0;
    case (i_op)
      LW:  o_misalign = (i_lane != 2'b00);
      LH:  begin
        o_misalign = i_lane[0];
        o_ldata    = {{16{w_half[15]}}, w_half};
      end
      LHU: begin
        o_misalign = i_lane[0];
        o_ldata    = {16'h0000, w_half};
      end
      LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
      LBU: o_ldata = {24'h000000, w_byte};
      SW:  begin
        o_misalign = (i_lane != 2'b00);
        o_be       = 4'b1111;
      end
      SH:  begin
        o_misalign = i_lane[0];
        o_be       = 4'b0011 << i_lane;
        o_wd       = {2{i_wdata[15:0]}};
      end
      SB:  begin
        o_be = 4'b0001 << i_lane;
        o_wd = {4{i_wdata[7:0]}};
      end
      default: o_be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit: one request in flight, IDLE -> ACCESS -> RESP, misaligned
// requests skip ACCESS and answer with an address-error response.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic     clk,
  input logic     rst,
  dm_lsu_if.slave bus
);

  state_e            r_state;
  op_e               r_op;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_dm_a;
  logic [DATA_W-1:0] r_dm_wd;
  logic [3:0]        r_dm_write;
  logic [31:0]       r_dm_pc;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  exc_e              r_rsp_exc;
  logic [ADDR_W-1:0] r_rsp_badaddr;

  logic        w_req_ready;
  logic        w_accept;
  logic        w_in_access;
  op_e         w_op;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_ldata;
  logic        w_misalign;

  assign w_req_ready = (r_state == IDLE) || ((r_state == RESP) && bus.rsp_ready);
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_in_access = (r_state == ACCESS);

  // No accept can happen during ACCESS, so one lane unit serves both the
  // incoming request (store side) and the latched one (load side).
  assign w_op   = w_in_access ? r_op : bus.req_op;
  assign w_lane = w_in_access ? r_lane : bus.req_addr[1:0];

  dm_lsu_lane u_lane (
    .i_op       (w_op),
    .i_lane     (w_lane),
    .i_wdata    (bus.req_wdata),
    .i_rd       (bus.dm_rd),
    .o_be       (w_be),
    .o_wd       (w_wd),
    .o_ldata    (w_ldata),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_op          <= LW;
      r_lane        <= 2'b00;
      r_dm_a        <= '0;
      r_dm_wd       <= '0;
      r_dm_write    <= 4'b0000;
      r_dm_pc       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_exc     <= EXC_NONE;
      r_rsp_badaddr <= '0;
    end else begin
      case (r_state)
        ACCESS: begin
          r_dm_write  <= 4'b0000;
          r_rsp_rdata <= is_store(r_op) ? '0 : w_ldata;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready && !bus.req_valid) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: ;
      endcase

      // Accept overrides the RESP bookkeeping above for back-to-back issue.
      if (w_accept) begin
        r_op        <= bus.req_op;
        r_lane      <= bus.req_addr[1:0];
        r_rsp_rdata <= '0;
        if (w_misalign) begin
          r_rsp_valid   <= 1'b1;
          r_rsp_exc     <= is_store(bus.req_op) ? EXC_ADES : EXC_ADEL;
          r_rsp_badaddr <= bus.req_addr;
          r_state       <= RESP;
        end else begin
          r_rsp_valid   <= 1'b0;
          r_rsp_exc     <= EXC_NONE;
          r_rsp_badaddr <= '0;
          r_dm_a        <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          r_dm_wd       <= w_wd;
          r_dm_write    <= w_be;
          r_dm_pc       <= bus.req_pc;
          r_state       <= ACCESS;
        end
      end
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.dm_a        = r_dm_a;
  assign bus.dm_wd       = r_dm_wd;
  assign bus.dm_write    = r_dm_write;
  assign bus.dm_pc       = r_dm_pc;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_exc     = r_rsp_exc;
  assign bus.rsp_badaddr = r_rsp_badaddr;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu with a 16-word byte-enabled memory model.
module tb_dm_lsu;
  import dm_lsu_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  dm_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dm_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [16] = '{default: 32'h0};

  assign bus.dm_rd = mem[bus.dm_a[5:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++)
      if (bus.dm_write[i]) mem[bus.dm_a[5:2]][8*i +: 8] <= bus.dm_wd[8*i +: 8];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_pc    = pc;
  endtask

  // Issue from IDLE with rsp_ready high; returns response and cycles to rsp_valid.
  task automatic run_req(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic [31:0] exc,
                         output logic [31:0] badaddr, output int lat, output logic [3:0] we_or);
    bus.rsp_ready = 1'b1;
    drive(op, addr, wdata, 32'h0000_0400);
    tick();
    bus.req_valid = 1'b0;
    lat   = 1;
    we_or = bus.dm_write;
    while (!bus.rsp_valid && lat < 8) begin
      tick();
      lat++;
      we_or |= bus.dm_write;
    end
    rdata   = bus.rsp_rdata;
    exc     = {30'd0, bus.rsp_exc};
    badaddr = bus.rsp_badaddr;
    tick();
  endtask

  logic [31:0] rd, ex, ba, held;
  int          lat, t1;
  logic [3:0]  we;

  initial begin
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = LW;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_pc    = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_dm_write", {28'd0, bus.dm_write}, 32'd0);
    chk("rst_dm_a", bus.dm_a, 32'd0);
    rst = 1'b1;
    tick();

    // SB to lane 3, response held back one cycle to observe latency
    drive(SB, 32'h0000_1003, 32'h0000_00A5, 32'h0000_0100);
    tick();
    bus.req_valid = 1'b0;
    chk("sb_dm_a", bus.dm_a, 32'h0000_1000);
    chk("sb_dm_write", {28'd0, bus.dm_write}, 32'h8);
    chk("sb_dm_wd", bus.dm_wd, 32'hA5A5_A5A5);
    chk("sb_dm_pc", bus.dm_pc, 32'h0000_0100);
    chk("sb_k1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("sb_k1_req_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk("sb_k2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("sb_k2_exc", {30'd0, bus.rsp_exc}, 32'd0);
    chk("sb_k2_dm_write", {28'd0, bus.dm_write}, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("sb_idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("sb_mem", mem[0], 32'hA500_0000);

    // Loads from the word just written
    run_req(LB, 32'h0000_1003, 32'h0, rd, ex, ba, lat, we);
    chk("lb_rdata", rd, 32'hFFFF_FFA5);
    chk("lb_lat", lat, 2);
    run_req(LBU, 32'h0000_1003, 32'h0, rd, ex, ba, lat, we);
    chk("lbu_rdata", rd, 32'h0000_00A5);
    run_req(LH, 32'h0000_1002, 32'h0, rd, ex, ba, lat, we);
    chk("lh_rdata", rd, 32'hFFFF_A500);
    chk("lh_exc", ex, 32'd0);

    // Misaligned accesses
    run_req(LW, 32'h0000_2002, 32'h0, rd, ex, ba, lat, we);
    chk("lw_mis_exc", ex, 32'd1);
    chk("lw_mis_bad", ba, 32'h0000_2002);
    chk("lw_mis_lat", lat, 1);
    chk("lw_mis_we", {28'd0, we}, 32'd0);
    chk("lw_mis_rdata", rd, 32'd0);
    run_req(SH, 32'h0000_2001, 32'h0000_BEEF, rd, ex, ba, lat, we);
    chk("sh_mis_exc", ex, 32'd2);
    chk("sh_mis_bad", ba, 32'h0000_2001);
    chk("sh_mis_we", {28'd0, we}, 32'd0);
    chk("sh_mis_mem", mem[0], 32'hA500_0000);

    // Back-pressure then simultaneous consume + accept
    bus.rsp_ready = 1'b0;
    drive(LW, 32'h0000_1000, 32'h0, 32'h0000_0200);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    held = bus.rsp_rdata;
    chk("bp_rdata", held, 32'hA500_0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_rdata", bus.rsp_rdata, held);
      chk("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("bp_dm_write", {28'd0, bus.dm_write}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    drive(SB, 32'h0000_1001, 32'h0000_005A, 32'h0000_0204);
    #1;
    chk("bp_accept_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("bp_next_dm_write", {28'd0, bus.dm_write}, 32'h2);
    chk("bp_next_dm_wd", bus.dm_wd, 32'h5A5A_5A5A);
    chk("bp_next_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("bp_next_resp", {31'd0, bus.rsp_valid}, 32'd1);
    tick();
    chk("bp_next_mem", mem[0], 32'hA500_5A00);

    // Back-to-back store then load of the stored word
    drive(SW, 32'h0000_0010, 32'h1234_5678, 32'h0000_0300);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("b2b_rsp1_valid", {31'd0, bus.rsp_valid}, 32'd1);
    t1 = cyc;
    drive(LHU, 32'h0000_0012, 32'h0, 32'h0000_0304);
    #1;
    chk("b2b_ready_in_resp", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("b2b_access_valid", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("b2b_rsp2_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("b2b_rdata", bus.rsp_rdata, 32'h0000_1234);
    chk("b2b_spacing", cyc - t1, 2);
    tick();

    // Reset asserted in the middle of a store's ACCESS cycle
    drive(SW, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_0500);
    tick();
    bus.req_valid = 1'b0;
    chk("rst_mid_pre_write", {28'd0, bus.dm_write}, 32'hF);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_dm_write", {28'd0, bus.dm_write}, 32'd0);
    chk("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    chk("rst_mid_mem", mem[8], 32'd0);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
